exec_wb_arbiter: RTL and testbench
==================================

EXEC_WB_ARBITER -- requirements
Module: exec_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: iCLOCK (input, 1, rising-edge clock) and iRESET_SYNC (input, 1, synchronous active-high reset).
REQ-002 Per requester X in {ADDER=0, LOGIC=1, SHIFT=2, MUL=3}, the block SHALL have:
- iX_VALID, input, 1: request.
- iX_DATA, input, 32: result.
- iX_FLAG, input, 5: flags.
- iX_FLAG_WRITE, input, 1: flags are to be written.
- iX_DESTINATION, input, 5: destination register.
- oX_ACK, output, 1: request accepted this cycle.
REQ-003 Control inputs SHALL be iFREE_PIPELINE (input, 1, flush) and iNEXT_BUSY (input, 1, downstream stall).
REQ-004 Writeback outputs SHALL be:
- oWB_VALID, output, 1.
- oWB_DATA, output, 32.
- oWB_FLAG, output, 5.
- oWB_FLAG_WRITE, output, 1.
- oWB_DESTINATION, output, 5.
- oWB_SOURCE, output, 2: granted requester index.

Function
REQ-005 Handshake: a requester SHALL hold VALID and payload stable until the cycle its oX_ACK=1; that cycle is the transfer.
REQ-006 oX_ACK SHALL be combinational and asserted for at most one requester per cycle.
REQ-007 The output register SHALL be "free" when oWB_VALID=0 or iNEXT_BUSY=0.
REQ-008 A grant SHALL occur only when the output register is free, iFREE_PIPELINE=0, and at least one iX_VALID=1.
REQ-009 Arbitration SHALL be round-robin over a 2-bit pointer P: search order P, P+1, P+2, P+3 mod 4; the first valid requester wins.
REQ-010 After a grant to index g, P SHALL become (g+1) mod 4 on the next edge; with no grant, P SHALL be unchanged.
REQ-011 On a grant, oWB_* SHALL load the winner's payload on the next edge, oWB_VALID=1, and oWB_SOURCE=g (latency one cycle from ACK).
REQ-012 When the output register is free and no grant occurs, oWB_VALID SHALL become 0 next cycle.
REQ-013 While oWB_VALID=1 and iNEXT_BUSY=1, all oWB_* SHALL hold unchanged and every oX_ACK SHALL be 0.
REQ-014 Simultaneous drain and grant (oWB_VALID=1, iNEXT_BUSY=0, request present) SHALL sustain back-to-back transfers, one per cycle.
REQ-015 iFREE_PIPELINE=1 SHALL force every oX_ACK=0 and clear oWB_VALID on the next edge regardless of iNEXT_BUSY; P SHALL be unchanged.
REQ-016 oWB_DATA, oWB_FLAG, oWB_FLAG_WRITE and oWB_DESTINATION SHALL be don't-care while oWB_VALID=0, but SHALL be cleared to 0 by reset.
REQ-017 A requester that stays valid SHALL be granted within 4 grants (starvation bound).

Reset
REQ-018 iRESET_SYNC=1 at an edge SHALL set oWB_VALID=0, all oWB_* payload fields=0, oWB_SOURCE=0 and P=0 (ADDER first).
REQ-019 While iRESET_SYNC=1, every oX_ACK SHALL be 0.
REQ-020 Reset SHALL take priority over iFREE_PIPELINE and over grants; a transfer in flight is discarded.

Structure
REQ-021 A shared package SHALL hold the requester index constants (ADDER=0, LOGIC=1, SHIFT=2, MUL=3) and the widths (DATA=32, FLAG=5, DEST=5).
REQ-022 The round-robin selector SHALL be one combinational sub-module, exec_wb_rr_select (inputs: 4-bit request and P; outputs: one-hot grant and 2-bit index).
REQ-023 The pointer and output register SHALL be sequential in exec_wb_arbiter.

Verification
REQ-024 After reset, with ADDER and MUL both valid (ADDER_DATA=0x11, MUL_DATA=0x44): ACK_ADDER first; next cycle oWB_DATA=0x11 and oWB_SOURCE=0; then ACK_MUL and oWB_DATA=0x44.
REQ-025 With all four valid for 8 cycles and iNEXT_BUSY=0, the grant sequence SHALL be 0,1,2,3,0,1,2,3 with oWB_VALID=1 continuously from cycle 2.
REQ-026 With oWB_VALID=1 (SHIFT, FLAG=5'b10100) and iNEXT_BUSY=1 for 3 cycles: outputs hold and no ACK; on release, the next grant appears one cycle later.
REQ-027 With iFREE_PIPELINE=1 for one cycle while LOGIC is valid and oWB_VALID=1: no ACK, oWB_VALID=0 next cycle, and LOGIC is granted the cycle after flush deasserts.
REQ-028 iRESET_SYNC asserted mid-stream with P=2 and oWB_VALID=1: next cycle oWB_VALID=0 and P=0; with SHIFT and ADDER valid, ADDER is granted first.
REQ-029 With MUL held valid under random traffic from the other three requesters, MUL SHALL be acknowledged within 4 grants.

Source files
------------

// File: rtl/exec_wb_arbiter_pkg.sv
// Shared definitions for the execution-unit writeback arbiter.
// Holds the requester index constants, the payload field widths, the
// packed payload record carried from a requester to the writeback register,
// and a helper that advances the round-robin pointer.
package exec_wb_arbiter_pkg;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 32;
   localparam int FLAG_W  = 5;
   localparam int DEST_W  = 5;

   typedef logic [1:0] req_idx_t;

   localparam req_idx_t IDX_ADDER = 2'd0;
   localparam req_idx_t IDX_LOGIC = 2'd1;
   localparam req_idx_t IDX_SHIFT = 2'd2;
   localparam req_idx_t IDX_MUL   = 2'd3;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [FLAG_W-1:0] flag;
      logic              flag_write;
      logic [DEST_W-1:0] destination;
   } wb_payload_t;

   // The requester after the winner gets first look next time; the 2-bit
   // width makes the wrap from MUL back to ADDER automatic.
   function automatic req_idx_t next_ptr(input req_idx_t granted);
      return granted + 2'd1;
   endfunction

endpackage

// File: rtl/exec_wb_arbiter_if.sv
// Bus bundle between the four execution units, the writeback arbiter and
// the downstream writeback stage.
//   iX_VALID/DATA/FLAG/FLAG_WRITE/DESTINATION : per-requester result payload
//   oX_ACK                                     : transfer accepted this cycle
//   iFREE_PIPELINE                             : flush
//   iNEXT_BUSY                                 : downstream stall
//   oWB_*                                      : registered writeback result
// Modport slave is the arbiter's view; master is the surrounding pipeline.
interface exec_wb_arbiter_if;
   import exec_wb_arbiter_pkg::*;

   logic              iADDER_VALID;
   logic [DATA_W-1:0] iADDER_DATA;
   logic [FLAG_W-1:0] iADDER_FLAG;
   logic              iADDER_FLAG_WRITE;
   logic [DEST_W-1:0] iADDER_DESTINATION;
   logic              oADDER_ACK;

   logic              iLOGIC_VALID;
   logic [DATA_W-1:0] iLOGIC_DATA;
   logic [FLAG_W-1:0] iLOGIC_FLAG;
   logic              iLOGIC_FLAG_WRITE;
   logic [DEST_W-1:0] iLOGIC_DESTINATION;
   logic              oLOGIC_ACK;

   logic              iSHIFT_VALID;
   logic [DATA_W-1:0] iSHIFT_DATA;
   logic [FLAG_W-1:0] iSHIFT_FLAG;
   logic              iSHIFT_FLAG_WRITE;
   logic [DEST_W-1:0] iSHIFT_DESTINATION;
   logic              oSHIFT_ACK;

   logic              iMUL_VALID;
   logic [DATA_W-1:0] iMUL_DATA;
   logic [FLAG_W-1:0] iMUL_FLAG;
   logic              iMUL_FLAG_WRITE;
   logic [DEST_W-1:0] iMUL_DESTINATION;
   logic              oMUL_ACK;

   logic              iFREE_PIPELINE;
   logic              iNEXT_BUSY;

   logic              oWB_VALID;
   logic [DATA_W-1:0] oWB_DATA;
   logic [FLAG_W-1:0] oWB_FLAG;
   logic              oWB_FLAG_WRITE;
   logic [DEST_W-1:0] oWB_DESTINATION;
   logic [1:0]        oWB_SOURCE;

   modport slave (
      input  iADDER_VALID, iADDER_DATA, iADDER_FLAG, iADDER_FLAG_WRITE, iADDER_DESTINATION,
      input  iLOGIC_VALID, iLOGIC_DATA, iLOGIC_FLAG, iLOGIC_FLAG_WRITE, iLOGIC_DESTINATION,
      input  iSHIFT_VALID, iSHIFT_DATA, iSHIFT_FLAG, iSHIFT_FLAG_WRITE, iSHIFT_DESTINATION,
      input  iMUL_VALID, iMUL_DATA, iMUL_FLAG, iMUL_FLAG_WRITE, iMUL_DESTINATION,
      input  iFREE_PIPELINE, iNEXT_BUSY,
      output oADDER_ACK, oLOGIC_ACK, oSHIFT_ACK, oMUL_ACK,
      output oWB_VALID, oWB_DATA, oWB_FLAG, oWB_FLAG_WRITE, oWB_DESTINATION, oWB_SOURCE
   );

   modport master (
      output iADDER_VALID, iADDER_DATA, iADDER_FLAG, iADDER_FLAG_WRITE, iADDER_DESTINATION,
      output iLOGIC_VALID, iLOGIC_DATA, iLOGIC_FLAG, iLOGIC_FLAG_WRITE, iLOGIC_DESTINATION,
      output iSHIFT_VALID, iSHIFT_DATA, iSHIFT_FLAG, iSHIFT_FLAG_WRITE, iSHIFT_DESTINATION,
      output iMUL_VALID, iMUL_DATA, iMUL_FLAG, iMUL_FLAG_WRITE, iMUL_DESTINATION,
      output iFREE_PIPELINE, iNEXT_BUSY,
      input  oADDER_ACK, oLOGIC_ACK, oSHIFT_ACK, oMUL_ACK,
      input  oWB_VALID, oWB_DATA, oWB_FLAG, oWB_FLAG_WRITE, oWB_DESTINATION, oWB_SOURCE
   );

endinterface

// File: rtl/exec_wb_rr_select.sv
// Combinational round-robin selector.
//   req       : one bit per requester, indexed by requester number
//   ptr       : requester that gets first look this cycle
//   grant     : one-hot winner (all zero when nothing requests)
//   grant_idx : binary index of the winner (equals ptr when nothing requests)
module exec_wb_rr_select
   import exec_wb_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  req_idx_t           ptr,
   output logic [NUM_REQ-1:0] grant,
   output req_idx_t           grant_idx
);

   logic     found;
   req_idx_t idx;

   // Walk ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first active request wins
   // and 'found' stops later positions from overriding it.
   always_comb begin
      grant     = '0;
      grant_idx = ptr;
      found     = 1'b0;
      idx       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/exec_wb_arbiter.sv
// Writeback arbiter: picks one of four execution-unit results per cycle
// (round robin) and registers it for the writeback stage.
//   iCLOCK      : rising-edge clock
//   iRESET_SYNC : synchronous active-high reset
//   bus         : requester payloads/acks, flush, downstream stall and the
//                 registered oWB_* result (see exec_wb_arbiter_if)
module exec_wb_arbiter
   import exec_wb_arbiter_pkg::*;
(
   input  logic              iCLOCK,
   input  logic              iRESET_SYNC,
   exec_wb_arbiter_if.slave  bus
);

   logic [NUM_REQ-1:0] req;
   wb_payload_t        req_payload [NUM_REQ];
   logic [NUM_REQ-1:0] sel_grant;
   req_idx_t           sel_idx;
   logic               wb_free;
   logic               grant_en;

   logic        wb_valid_q,   wb_valid_d;
   wb_payload_t wb_payload_q, wb_payload_d;
   req_idx_t    wb_source_q,  wb_source_d;
   req_idx_t    ptr_q,        ptr_d;

   // Gather the per-requester signals into indexable form.
   always_comb begin
      req[IDX_ADDER] = bus.iADDER_VALID;
      req[IDX_LOGIC] = bus.iLOGIC_VALID;
      req[IDX_SHIFT] = bus.iSHIFT_VALID;
      req[IDX_MUL]   = bus.iMUL_VALID;
      req_payload[IDX_ADDER] = '{bus.iADDER_DATA, bus.iADDER_FLAG, bus.iADDER_FLAG_WRITE, bus.iADDER_DESTINATION};
      req_payload[IDX_LOGIC] = '{bus.iLOGIC_DATA, bus.iLOGIC_FLAG, bus.iLOGIC_FLAG_WRITE, bus.iLOGIC_DESTINATION};
      req_payload[IDX_SHIFT] = '{bus.iSHIFT_DATA, bus.iSHIFT_FLAG, bus.iSHIFT_FLAG_WRITE, bus.iSHIFT_DESTINATION};
      req_payload[IDX_MUL]   = '{bus.iMUL_DATA, bus.iMUL_FLAG, bus.iMUL_FLAG_WRITE, bus.iMUL_DESTINATION};
   end

   exec_wb_rr_select u_select (
      .req       (req),
      .ptr       (ptr_q),
      .grant     (sel_grant),
      .grant_idx (sel_idx)
   );

   // The output register can take a new result if it is empty or being
   // drained this cycle. Reset and flush both veto any transfer so that a
   // requester never sees an ACK for a result that would be discarded.
   always_comb begin
      wb_free  = !wb_valid_q || !bus.iNEXT_BUSY;
      grant_en = wb_free && !bus.iFREE_PIPELINE && !iRESET_SYNC && (|req);
   end

   always_comb begin
      bus.oADDER_ACK = grant_en && sel_grant[IDX_ADDER];
      bus.oLOGIC_ACK = grant_en && sel_grant[IDX_LOGIC];
      bus.oSHIFT_ACK = grant_en && sel_grant[IDX_SHIFT];
      bus.oMUL_ACK   = grant_en && sel_grant[IDX_MUL];
   end

   // Next state of the writeback register and pointer. Flush empties the
   // register even while stalled; payload is left alone since it is
   // don't-care once invalid. The pointer moves only on a real grant.
   always_comb begin
      wb_valid_d   = wb_valid_q;
      wb_payload_d = wb_payload_q;
      wb_source_d  = wb_source_q;
      ptr_d        = ptr_q;
      if (bus.iFREE_PIPELINE) begin
         wb_valid_d = 1'b0;
      end else if (grant_en) begin
         wb_valid_d   = 1'b1;
         wb_payload_d = req_payload[sel_idx];
         wb_source_d  = sel_idx;
         ptr_d        = next_ptr(sel_idx);
      end else if (wb_free) begin
         wb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         wb_valid_q   <= 1'b0;
         wb_payload_q <= '0;
         wb_source_q  <= IDX_ADDER;
         ptr_q        <= IDX_ADDER;
      end else begin
         wb_valid_q   <= wb_valid_d;
         wb_payload_q <= wb_payload_d;
         wb_source_q  <= wb_source_d;
         ptr_q        <= ptr_d;
      end
   end

   always_comb begin
      bus.oWB_VALID       = wb_valid_q;
      bus.oWB_DATA        = wb_payload_q.data;
      bus.oWB_FLAG        = wb_payload_q.flag;
      bus.oWB_FLAG_WRITE  = wb_payload_q.flag_write;
      bus.oWB_DESTINATION = wb_payload_q.destination;
      bus.oWB_SOURCE      = wb_source_q;
   end

endmodule

// File: tb/tb_exec_wb_arbiter.sv
// Directed bench for exec_wb_arbiter, finishing with a random-traffic
// phase checked against a small reference model of the round robin.
module tb_exec_wb_arbiter;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int checks = 0;
   int errors = 0;

   exec_wb_arbiter_if bus();

   exec_wb_arbiter dut (
      .iCLOCK      (clk),
      .iRESET_SYNC (reset),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   logic [3:0] ackVec;
   assign ackVec = {bus.oMUL_ACK, bus.oSHIFT_ACK, bus.oLOGIC_ACK, bus.oADDER_ACK};

   // Fixed per-requester payloads so every result identifies its source.
   localparam logic [31:0] DATA_A = 32'h11, DATA_L = 32'h22, DATA_S = 32'h33, DATA_M = 32'h44;
   localparam logic [4:0]  FLAG_A = 5'h01,  FLAG_L = 5'h02,  FLAG_S = 5'b10100, FLAG_M = 5'h08;

   // Drive the four VALIDs as a vector {MUL, SHIFT, LOGIC, ADDER}.
   task automatic applyStimulus(input logic [3:0] v);
      bus.iADDER_VALID = v[0];
      bus.iLOGIC_VALID = v[1];
      bus.iSHIFT_VALID = v[2];
      bus.iMUL_VALID   = v[3];
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] dataOf(input int idx);
      case (idx)
         0: return DATA_A;
         1: return DATA_L;
         2: return DATA_S;
         default: return DATA_M;
      endcase
   endfunction

   logic [1:0] mP;
   logic       mValid;
   logic       mFree;
   logic [3:0] rq;
   logic [3:0] expAck;
   int         expIdx;
   int         othersSince;

   initial begin
      bus.iADDER_DATA = DATA_A; bus.iADDER_FLAG = FLAG_A; bus.iADDER_FLAG_WRITE = 1'b1; bus.iADDER_DESTINATION = 5'd1;
      bus.iLOGIC_DATA = DATA_L; bus.iLOGIC_FLAG = FLAG_L; bus.iLOGIC_FLAG_WRITE = 1'b0; bus.iLOGIC_DESTINATION = 5'd2;
      bus.iSHIFT_DATA = DATA_S; bus.iSHIFT_FLAG = FLAG_S; bus.iSHIFT_FLAG_WRITE = 1'b1; bus.iSHIFT_DESTINATION = 5'd3;
      bus.iMUL_DATA   = DATA_M; bus.iMUL_FLAG   = FLAG_M; bus.iMUL_FLAG_WRITE   = 1'b0; bus.iMUL_DESTINATION   = 5'd4;
      bus.iFREE_PIPELINE = 1'b0;
      bus.iNEXT_BUSY     = 1'b0;
      applyStimulus(4'b0000);

      // Reset state
      tick();
      checkOutput("rst_valid", 32'(bus.oWB_VALID), 0);
      checkOutput("rst_data", bus.oWB_DATA, 0);
      checkOutput("rst_flag", 32'(bus.oWB_FLAG), 0);
      checkOutput("rst_fw", 32'(bus.oWB_FLAG_WRITE), 0);
      checkOutput("rst_dest", 32'(bus.oWB_DESTINATION), 0);
      checkOutput("rst_src", 32'(bus.oWB_SOURCE), 0);
      applyStimulus(4'b1111);
      #1 checkOutput("rst_ack", 32'(ackVec), 0);
      tick();
      checkOutput("rst_valid2", 32'(bus.oWB_VALID), 0);

      // ADDER and MUL valid after reset
      reset = 1'b0;
      applyStimulus(4'b1001);
      #1 checkOutput("am_ack1", 32'(ackVec), 32'b0001);
      tick();
      checkOutput("am_valid1", 32'(bus.oWB_VALID), 1);
      checkOutput("am_data1", bus.oWB_DATA, 32'h11);
      checkOutput("am_src1", 32'(bus.oWB_SOURCE), 0);
      checkOutput("am_dest1", 32'(bus.oWB_DESTINATION), 1);
      applyStimulus(4'b1000);
      #1 checkOutput("am_ack2", 32'(ackVec), 32'b1000);
      tick();
      checkOutput("am_data2", bus.oWB_DATA, 32'h44);
      checkOutput("am_src2", 32'(bus.oWB_SOURCE), 3);
      checkOutput("am_fw2", 32'(bus.oWB_FLAG_WRITE), 0);
      applyStimulus(4'b0000);
      #1 checkOutput("idle_ack", 32'(ackVec), 0);
      tick();
      checkOutput("idle_valid", 32'(bus.oWB_VALID), 0);

      // All four valid for 8 cycles, no stall: 0,1,2,3,0,1,2,3
      applyStimulus(4'b1111);
      for (int k = 0; k < 8; k++) begin
         #1 checkOutput($sformatf("rr_ack%0d", k), 32'(ackVec), 32'(4'b0001 << (k % 4)));
         tick();
         checkOutput($sformatf("rr_valid%0d", k), 32'(bus.oWB_VALID), 1);
         checkOutput($sformatf("rr_src%0d", k), 32'(bus.oWB_SOURCE), 32'(k % 4));
         checkOutput($sformatf("rr_data%0d", k), bus.oWB_DATA, dataOf(k % 4));
      end
      applyStimulus(4'b0000);

      // Stall holding a SHIFT result (pointer is back at 0)
      applyStimulus(4'b0100);
      #1 checkOutput("st_ack_shift", 32'(ackVec), 32'b0100);
      tick();
      checkOutput("st_flag", 32'(bus.oWB_FLAG), 32'(5'b10100));
      applyStimulus(4'b0001);
      bus.iNEXT_BUSY = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 checkOutput($sformatf("st_noack%0d", k), 32'(ackVec), 0);
         tick();
         checkOutput($sformatf("st_valid%0d", k), 32'(bus.oWB_VALID), 1);
         checkOutput($sformatf("st_src%0d", k), 32'(bus.oWB_SOURCE), 2);
         checkOutput($sformatf("st_data%0d", k), bus.oWB_DATA, DATA_S);
         checkOutput($sformatf("st_flag%0d", k), 32'(bus.oWB_FLAG), 32'(5'b10100));
      end
      bus.iNEXT_BUSY = 1'b0;
      #1 checkOutput("st_rel_ack", 32'(ackVec), 32'b0001);
      tick();
      checkOutput("st_rel_src", 32'(bus.oWB_SOURCE), 0);
      checkOutput("st_rel_data", bus.oWB_DATA, DATA_A);

      // Flush one cycle while LOGIC waits (pointer now 1)
      applyStimulus(4'b0010);
      bus.iFREE_PIPELINE = 1'b1;
      #1 checkOutput("fl_noack", 32'(ackVec), 0);
      tick();
      checkOutput("fl_valid", 32'(bus.oWB_VALID), 0);
      bus.iFREE_PIPELINE = 1'b0;
      #1 checkOutput("fl_ack_logic", 32'(ackVec), 32'b0010);
      tick();
      checkOutput("fl_src", 32'(bus.oWB_SOURCE), 1);
      checkOutput("fl_data", bus.oWB_DATA, DATA_L);
      checkOutput("fl_valid2", 32'(bus.oWB_VALID), 1);
      // Flush beats a stall
      applyStimulus(4'b0000);
      bus.iNEXT_BUSY = 1'b1;
      bus.iFREE_PIPELINE = 1'b1;
      tick();
      checkOutput("fl_busy_valid", 32'(bus.oWB_VALID), 0);
      bus.iNEXT_BUSY = 1'b0;
      bus.iFREE_PIPELINE = 1'b0;

      // Pointer is 2; grant LOGIC (2,3,0,1 -> 1) leaves pointer 2, valid 1
      applyStimulus(4'b0010);
      #1 checkOutput("mr_ack_logic", 32'(ackVec), 32'b0010);
      tick();
      checkOutput("mr_valid", 32'(bus.oWB_VALID), 1);
      // Mid-stream reset with SHIFT and ADDER waiting
      applyStimulus(4'b0101);
      reset = 1'b1;
      #1 checkOutput("mr_ack_rst", 32'(ackVec), 0);
      tick();
      checkOutput("mr_valid_rst", 32'(bus.oWB_VALID), 0);
      checkOutput("mr_data_rst", bus.oWB_DATA, 0);
      checkOutput("mr_src_rst", 32'(bus.oWB_SOURCE), 0);
      reset = 1'b0;
      #1 checkOutput("mr_ack_adder", 32'(ackVec), 32'b0001);
      tick();
      checkOutput("mr_src_adder", 32'(bus.oWB_SOURCE), 0);

      // Random traffic with MUL held valid; reference model from here:
      // pointer 1, register holding ADDER's result.
      mP = 2'd1;
      mValid = 1'b1;
      othersSince = 0;
      for (int k = 0; k < 40; k++) begin
         rq = {1'b1, 3'($urandom_range(0, 7))};
         bus.iNEXT_BUSY = ($urandom_range(0, 3) == 0);
         applyStimulus(rq);
         mFree = !mValid || !bus.iNEXT_BUSY;
         expAck = '0;
         expIdx = -1;
         if (mFree) begin
            for (int j = 0; j < 4; j++) begin
               if (expIdx < 0 && rq[(int'(mP) + j) % 4]) expIdx = (int'(mP) + j) % 4;
            end
            expAck[expIdx] = 1'b1;
         end
         #1 checkOutput($sformatf("rnd_ack%0d", k), 32'(ackVec), 32'(expAck));
         tick();
         if (expIdx >= 0) begin
            mValid = 1'b1;
            mP = 2'(expIdx + 1);
            checkOutput($sformatf("rnd_src%0d", k), 32'(bus.oWB_SOURCE), 32'(expIdx));
            if (expIdx == 3) begin
               checkOutput($sformatf("rnd_starve%0d", k), 32'(othersSince <= 3), 1);
               othersSince = 0;
            end else begin
               othersSince++;
            end
         end else if (mFree) begin
            mValid = 1'b0;
         end
         checkOutput($sformatf("rnd_valid%0d", k), 32'(bus.oWB_VALID), 32'(mValid));
      end
      checkOutput("rnd_starve_end", 32'(othersSince <= 3), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
